// File: rtl/fifo_rr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle for fifo_rr_arbiter.
// master: arbiter side; slave: producers and FIFO side.
interface fifo_rr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [IdxW-1:0]               owner;
    logic                          owner_vld;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_data_in, owner, owner_vld
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_data_in, owner, owner_vld
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional FIFO_RR_ARBITER_PRIO0_EN: producer 0 preempts any burst whenever the FIFO has room.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_rr_arbiter_if.master bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0] rr_req;
    logic               prio_hit;
    logic               rr_blocked;
    logic [IdxW:0]      cand;
    logic               rr_gnt_vld;
    logic [IdxW-1:0]    rr_gnt_idx;

    function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] idx);
        return (idx == IdxW'(NUM_REQ - 1)) ? '0 : idx + IdxW'(1);
    endfunction

    // Returns {found, index} of the first set bit scanning upward from start with wrap.
    function automatic logic [IdxW:0] scan(input logic [NUM_REQ-1:0] r,
                                           input logic [IdxW-1:0]    start);
        logic [IdxW-1:0] idx;
        logic [IdxW:0]   res;
        res = '0;
        idx = start;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!res[IdxW] && r[idx]) begin
                res = {1'b1, idx};
            end
            idx = inc_idx(idx);
        end
        return res;
    endfunction

`ifdef FIFO_RR_ARBITER_PRIO0_EN
    assign prio_hit = bus.req[0] & ~bus.fifo_full;
    assign rr_req   = bus.req & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
    assign prio_hit = 1'b0;
    assign rr_req   = bus.req;
`endif
    // An urgent grant stalls the round-robin side exactly like a full FIFO.
    assign rr_blocked = bus.fifo_full | prio_hit;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rr_gnt_vld  = 1'b0;
        rr_gnt_idx  = owner_q;
        cand        = '0;
        if (state_q == StIdle) begin
            cand = scan(rr_req, rr_ptr_q);
            if (cand[IdxW] && !rr_blocked) begin
                rr_gnt_vld  = 1'b1;
                rr_gnt_idx  = cand[IdxW-1:0];
                state_d     = StBurst;
                owner_d     = cand[IdxW-1:0];
                burst_cnt_d = 4'd1;
            end
        end else if (!rr_req[owner_q] || burst_cnt_q == 4'(BURST_LEN)) begin
            cand = scan(rr_req, inc_idx(owner_q));
            if (cand[IdxW]) begin
                owner_d  = cand[IdxW-1:0];
                rr_ptr_d = inc_idx(cand[IdxW-1:0]);
                if (!rr_blocked) begin
                    rr_gnt_vld  = 1'b1;
                    rr_gnt_idx  = cand[IdxW-1:0];
                    burst_cnt_d = 4'd1;
                end else begin
                    burst_cnt_d = 4'd0;
                end
            end else begin
                state_d     = StIdle;
                rr_ptr_d    = inc_idx(owner_q);
                burst_cnt_d = 4'd0;
            end
        end else if (!rr_blocked) begin
            rr_gnt_vld  = 1'b1;
            rr_gnt_idx  = owner_q;
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    // Outputs are gated by reset so nothing is written while rst is low.
    always_comb begin
        bus.gnt          = '0;
        bus.fifo_data_in = '0;
        if (rst) begin
            if (prio_hit) begin
                bus.gnt[0]       = 1'b1;
                bus.fifo_data_in = bus.req_data[0 +: DATA_WIDTH];
            end else if (rr_gnt_vld) begin
                bus.gnt[rr_gnt_idx] = 1'b1;
                bus.fifo_data_in    = bus.req_data[rr_gnt_idx * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.fifo_wr_en = |bus.gnt;
    assign bus.owner      = owner_q;
    assign bus.owner_vld  = (state_q == StBurst);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Shares the write port of one `fifo` instance among NUM_REQ producers.
- Arbitration is round-robin with a bounded burst per grant, so a single producer cannot starve the others.
- Each producer uses a valid/ready handshake (req/gnt). The block drives the FIFO's wr_en/data_in directly and obeys its full flag.
- Sits between producer blocks and the FIFO; no data is buffered inside the arbiter.

Parameters:
- DATA_WIDTH, 8, width of each producer word and of the FIFO data_in.
- NUM_REQ, 4, number of producers (2..8).
- BURST_LEN, 4, maximum consecutive words granted to one producer per tenure (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-producer valid; producer holds req and its data stable until a transfer occurs.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i's word is bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot ready; transfer of producer i happens at the rising edge where req[i] and gnt[i] are both high.
- fifo_full  input  1  full flag from the FIFO.
- fifo_wr_en  output  1  FIFO write enable; equals OR of gnt.
- fifo_data_in  output  DATA_WIDTH  word of the granted producer; all zeros when no grant.
- owner  output  $clog2(NUM_REQ)  registered index of the current burst holder.
- owner_vld  output  1  registered; high while state is BURST.

Behaviour:
- While rst is low: gnt=0, fifo_wr_en=0, fifo_data_in=0, owner=0, owner_vld=0, burst_cnt=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-burst aborts the burst immediately; no write occurs at any edge while rst is low.
- gnt, fifo_wr_en and fifo_data_in are combinational from registered state, req and fifo_full.
- Latency: a word is written to the FIFO at the same edge it is accepted; zero bubble between grants.
- Nothing is granted while fifo_full=1. The FIFO's own full update after that edge governs the next cycle.
- State IDLE:
  - Candidate is the first requester with req high, scanning from rr_ptr upward with wrap-around.
  - If a candidate exists and fifo_full=0, grant it; at the edge go to BURST with owner=candidate, burst_cnt=1.
- State BURST, owner continues:
  - Condition: req[owner]=1, burst_cnt<BURST_LEN and fifo_full=0.
  - Grant owner; burst_cnt increments at the edge.
- State BURST, owner releases:
  - Condition: req[owner]=0, or burst_cnt==BURST_LEN.
  - In that same cycle, select the next candidate scanning from owner+1 with wrap-around.
  - The scan reaches owner last, so owner is re-granted only if it is the sole requester.
  - If a candidate exists and fifo_full=0: grant it and start a new burst (owner=candidate, burst_cnt=1). Set rr_ptr=candidate+1 mod NUM_REQ.
  - If no candidate: go to IDLE and set rr_ptr=owner+1 mod NUM_REQ.
- BURST with fifo_full=1: no grant; state, owner and burst_cnt hold (stall, not release).
- Release is evaluated first even while full. If owner dropped req, ownership passes to the candidate with burst_cnt=0 and state BURST, and the candidate is granted when full clears.
- rr_ptr arithmetic wraps modulo NUM_REQ. burst_cnt width is 4 bits.
- Simultaneous requests are ordered strictly by scan order from the pointer; there is no fixed priority.
- gnt is always one-hot or zero.

Optional Feature:
- Macro: FIFO_RR_ARBITER_PRIO0_EN.
- When defined, producer 0 is urgent:
  - If req[0]=1 and fifo_full=0, producer 0 is granted regardless of state, preempting any burst.
  - The preempted owner keeps its burst_cnt and resumes when req[0] drops.
  - Producer 0's grants do not count against any burst.
- When not defined, producer 0 is an ordinary round-robin participant.

Test Plan:
- Reset: rst=0 with req=4'b1111 and data 8'hA0..A3 for 3 cycles -> gnt=0, fifo_wr_en=0, owner_vld=0. Release rst -> gnt=4'b0001 in the first cycle and FIFO receives 8'hA0.
- Reset mid-burst: assert rst low after 2 words of producer 1 -> next cycle gnt=0, owner_vld=0. After release, the first grant goes to producer 0 (rr_ptr=0).
- Sole requester: producer 2 streams 8'h10..8'h17 continuously -> gnt=4'b0100 for 8 consecutive cycles, FIFO cnt rises by 8, no idle cycle at the BURST_LEN boundary.
- Round-robin: all four request continuously -> grants in blocks of 4 in the order 0,1,2,3,0. The FIFO contents follow that order exactly.
- Early release and full stall:
  - Producer 0 drops req after 2 words while producers 1 and 3 are pending -> gnt=4'b0010 in the very next cycle.
  - Hold fifo_full=1 for 3 cycles after producer 1's second word -> gnt=0 and fifo_wr_en=0 for those cycles.
  - Producer 1 then gets its remaining 2 words, followed by producer 3.
- Priority macro: during producer 3's burst, assert req[0] with 8'hEE.
  - Macro defined -> gnt=4'b0001 next cycle and 8'hEE is written, then producer 3 resumes.
  - Macro undefined -> producer 0 waits until producer 3's burst ends.
